// File: rtl/alarm_ringer.sv
// alarm_ringer: ring/snooze/stop alarm FSM with second timers; ALARM_SNOOZE_LIMIT_EN caps snoozes at MAX_SNOOZE
module alarm_ringer #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       z,
  input  logic       alarm_en,
  input  logic       stop,
  input  logic       snooze,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic       missed,
  output logic [3:0] snooze_cnt
);
  localparam int TMAX = RING_TIMEOUT_S > SNOOZE_S ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RING_T = TW'(RING_TIMEOUT_S);
  localparam logic [TW-1:0] SNZ_T = TW'(SNOOZE_S);
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZING} state_t;
  state_t state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [3:0] cnt_d;
  logic z_q, stop_q, snooze_q, phase, phase_d, missed_d;
  logic trig, stop_p, snz_p, snz_ok, expiry, quit;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      snooze_cnt <= '0;
      z_q <= 1'b0;
      stop_q <= 1'b0;
      snooze_q <= 1'b0;
      phase <= 1'b0;
      missed <= 1'b0;
    end else begin
      state <= state_d;
      timer <= timer_d;
      snooze_cnt <= cnt_d;
      z_q <= z;
      stop_q <= stop;
      snooze_q <= snooze;
      phase <= phase_d;
      missed <= missed_d;
    end
  end
  always_comb begin
    trig = z & ~z_q & alarm_en;
    stop_p = stop & ~stop_q;
    snz_p = snooze & ~snooze_q;
`ifdef ALARM_SNOOZE_LIMIT_EN
    snz_ok = snz_p && (int'(snooze_cnt) < MAX_SNOOZE);
`else
    snz_ok = snz_p;
`endif
    expiry = sec_tick && timer == TW'(1);
    quit = stop_p || !alarm_en;
    state_d = state;
    timer_d = (sec_tick && timer != '0) ? timer - 1'b1 : timer;
    cnt_d = snooze_cnt;
    phase_d = (state == RINGING && sec_tick) ? ~phase : phase;
    missed_d = missed;
    case (state)
      IDLE: begin
        if (stop_p) missed_d = 1'b0;
        if (trig) begin
          state_d = RINGING;
          timer_d = RING_T;
          cnt_d = '0;
          phase_d = 1'b1;
        end
      end
      RINGING: begin
        if (quit) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (snz_ok) begin
          state_d = SNOOZING;
          timer_d = SNZ_T;
          cnt_d = snooze_cnt == 4'hf ? snooze_cnt : snooze_cnt + 4'd1;
        end else if (expiry) begin
          state_d = IDLE;
          timer_d = '0;
          missed_d = 1'b1;
        end
      end
      SNOOZING: begin
        if (quit) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (expiry) begin
          state_d = RINGING;
          timer_d = RING_T;
          phase_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign ringing = state == RINGING;
  assign snoozing = state == SNOOZING;
  assign buzzer = ringing & phase;
endmodule

// File: doc/alarm_ringer.md
Name: alarm_ringer

Overview:
- Consumer end of the time/alarm digit interface: takes the alarm-match flag from the time/alarm block and drives the user-facing alarm response.
- Detects the rising edge of the match flag and runs a ring/snooze/stop state machine with second-based timers.
- Drives the buzzer, the snooze LED and status outputs. Sits between the time/alarm block and the board I/O.

Parameters:
- RING_TIMEOUT_S, 60, seconds the alarm rings unanswered before it auto-stops and sets the missed flag
- SNOOZE_S, 300, snooze duration in seconds
- MAX_SNOOZE, 3, snooze limit; used only when ALARM_SNOOZE_LIMIT_EN is defined

Ports:
- clk  input  1  system clock; the only clock
- rst  input  1  asynchronous, active-low reset
- sec_tick  input  1  one-clk-wide pulse, once per second, synchronous to clk
- z  input  1  alarm-match flag (alarm digits equal time digits); stays high for the whole matching minute
- alarm_en  input  1  alarm armed; level
- stop  input  1  stop button, debounced level
- snooze  input  1  snooze button, debounced level
- buzzer  output  1  buzzer drive
- ringing  output  1  state == RINGING
- snoozing  output  1  state == SNOOZING; also drives the snooze LED
- missed  output  1  sticky flag: a ring timed out unanswered
- snooze_cnt  output  4  number of snoozes in the current alarm event, saturates at 15

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; all outputs = 0.
  - Timers = 0; edge-detect registers for z, stop and snooze = 0.
- Edge detection: registered copies z_q, stop_q, snooze_q.
  - trig = z & ~z_q & alarm_en
  - stop_p = stop & ~stop_q
  - snz_p = snooze & ~snooze_q
  - All three are one-cycle pulses. Holding a button down acts once.
- States: IDLE, RINGING, SNOOZING. Next state is registered; ringing/snoozing go high the clk edge after the causing pulse (latency 1).
- Timer: one down-counter, width $clog2(max(RING_TIMEOUT_S, SNOOZE_S)+1).
  - Loaded on state entry; decremented only on sec_tick.
  - Expiry = sec_tick while timer == 1. So expiry falls on the Nth sec_tick after entry; a sec_tick in the entry cycle itself is not counted.
- IDLE:
  - trig -> RINGING; load RING_TIMEOUT_S; snooze_cnt = 0; blink phase = 1.
  - stop_p in IDLE clears missed.
- RINGING (priority highest first):
  - stop_p -> IDLE.
  - ~alarm_en -> IDLE.
  - snz_p -> SNOOZING; load SNOOZE_S; snooze_cnt++ (saturating).
  - expiry -> IDLE; missed = 1.
- SNOOZING (priority highest first):
  - stop_p -> IDLE.
  - ~alarm_en -> IDLE.
  - expiry -> RINGING; load RING_TIMEOUT_S; blink phase = 1.
  - snz_p ignored.
- trig while RINGING or SNOOZING is ignored: no reload, no reset of snooze_cnt.
- Buzzer: blink phase flips on every sec_tick while RINGING. buzzer = ringing & phase, so it is 1 on the first RINGING cycle and forced to 0 in all other states.
- Simultaneous stop_p and snz_p in RINGING: stop wins.
  - Expiry in the same cycle as stop_p: stop wins, missed is not set.
- missed stays set across later alarms. It is cleared only by stop_p in IDLE or by reset.
- z held high across a full SNOOZE period inside the same minute does not re-trigger; only a new rising edge does.

Optional Feature:
- Macro ALARM_SNOOZE_LIMIT_EN.
- Defined: in RINGING, snz_p is ignored once snooze_cnt >= MAX_SNOOZE; the alarm keeps ringing until stop, disarm or expiry.
- Undefined: snooze is always honoured; snooze_cnt saturates at 15 and MAX_SNOOZE is unused.

Test Plan (bench params RING_TIMEOUT_S=4, SNOOZE_S=3, MAX_SNOOZE=2):
- Reset with rst=0 mid-RINGING -> all outputs 0 immediately, without waiting for a clk edge; after release, state is IDLE.
- alarm_en=1, z rises -> ringing=1 one clk later, buzzer=1; buzzer toggles on each sec_tick; on the 4th sec_tick -> ringing=0, missed=1. A following stop pulse in IDLE -> missed=0.
- Ringing, press snooze -> snoozing=1, buzzer=0, snooze_cnt=1; on the 3rd sec_tick -> ringing=1, buzzer=1.
- Ringing, stop and snooze asserted in the same cycle -> IDLE, snooze_cnt unchanged, missed=0. With alarm_en=0, z rises -> stays IDLE.
- z held high through one snooze cycle -> no re-trigger or snooze_cnt reset; z falling and rising again while in IDLE -> new ring, snooze_cnt=0.
- With ALARM_SNOOZE_LIMIT_EN defined: third snooze press (snooze_cnt=2) -> remains RINGING. Without the macro -> SNOOZING, snooze_cnt=3.
